vga_timing_gen: RTL and testbench

//  Consumes the pixel clock and lock flag from the pixel clock generator.

---
 rtl/vga_timing_gen_pkg.sv | 29 ++
 rtl/vga_timing_gen_axis_counter.sv | 68 ++++++
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared phase encoding, default 640x480@60 timing and phase sequencing for the VGA raster.
package vga_timing_gen_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  function automatic phase_t phase_next(input phase_t p);
    case (p)
      PH_ACTIVE: phase_next = PH_FRONT;
      PH_FRONT:  phase_next = PH_SYNC;
      PH_SYNC:   phase_next = PH_BACK;
      default:   phase_next = PH_ACTIVE;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM, advanced by step.
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter int unsigned CW     = 10
) (
  input  logic          clk_pix,
  input  logic          resetn,
  input  logic          clr,
  input  logic          step,
  output logic [CW-1:0] cnt,
  output logic [1:0]    phase,
  output logic          wrap
);

  localparam int unsigned   TOTAL    = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] CNT_LAST = CW'(TOTAL - 1);

  phase_t        ph_q, ph_d;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] pc_q, pc_d;
  logic [CW-1:0] pc_last;

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      ph_q <= PH_ACTIVE;
      pc_q <= '0;
    end else begin
      cnt  <= cnt_d;
      ph_q <= ph_d;
      pc_q <= pc_d;
    end
  end

  always_comb begin
    cnt_d = cnt;
    ph_d  = ph_q;
    pc_d  = pc_q;
    case (ph_q)
      PH_ACTIVE: pc_last = CW'(ACTIVE - 1);
      PH_FRONT:  pc_last = CW'(FP - 1);
      PH_SYNC:   pc_last = CW'(SYNC - 1);
      default:   pc_last = CW'(BP - 1);
    endcase
    wrap = step && (cnt == CNT_LAST);
    if (clr) begin
      cnt_d = '0;
      ph_d  = PH_ACTIVE;
      pc_d  = '0;
    end else if (step) begin
      cnt_d = wrap ? '0 : cnt + CW'(1);
      if (pc_q == pc_last) begin
        ph_d = phase_next(ph_q);
        pc_d = '0;
      end else begin
        pc_d = pc_q + CW'(1);
      end
    end
  end

  assign phase = ph_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: H/V axis counters, lock-driven restart and registered sync/DE/coordinate outputs.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0,
  parameter int unsigned CW       = 10
) (
  input  logic          clk_pix,
  input  logic          resetn,
  input  logic          locked,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);

  logic [CW-1:0] hc, vc;
  logic [1:0]    h_phase_raw, v_phase_raw;
  phase_t        h_ph, v_ph;
  logic          h_wrap, v_wrap;
  logic          lock_clr;
  logic          origin_q;

  assign lock_clr = ~locked;
  assign h_ph     = phase_t'(h_phase_raw);
  assign v_ph     = phase_t'(v_phase_raw);

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CW     (CW)
  ) u_h_axis (
    .clk_pix (clk_pix),
    .resetn  (resetn),
    .clr     (lock_clr),
    .step    (locked),
    .cnt     (hc),
    .phase   (h_phase_raw),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CW     (CW)
  ) u_v_axis (
    .clk_pix (clk_pix),
    .resetn  (resetn),
    .clr     (lock_clr),
    .step    (h_wrap),
    .cnt     (vc),
    .phase   (v_phase_raw),
    .wrap    (v_wrap)
  );

  // origin_q tracks "counters sit at (0,0)" so frame_start needs no wide compare.
  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      origin_q    <= 1'b1;
    end else if (!locked) begin
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      origin_q    <= 1'b1;
    end else begin
      hsync       <= (h_ph == PH_SYNC) ? H_POL : ~H_POL;
      vsync       <= (v_ph == PH_SYNC) ? V_POL : ~V_POL;
      de          <= (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE);
      pixel_x     <= hc;
      pixel_y     <= vc;
      line_start  <= (hc == '0);
      frame_start <= origin_q;
      frame_cnt   <= frame_cnt + {7'd0, frame_start};
      origin_q    <= v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size timing for line/lock/reset behaviour, shrunken timing for frame-level and wrap behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, lk_a, lk_b;

  logic       a_hsync, a_vsync, a_de, a_ls, a_fs;
  logic [9:0] a_px, a_py;
  logic [7:0] a_fc;

  logic       b_hsync, b_vsync, b_de, b_ls, b_fs;
  logic [3:0] b_px, b_py;
  logic [7:0] b_fc;

  int checks = 0;
  int errors = 0;

  int de_n, hs_n, vs_n, ls_n, fs_n, de_late;
  int hs_first, hs_last, vs_first_x, vs_first_y;

  vga_timing_gen u_dut (
    .clk_pix     (clk),
    .resetn      (resetn),
    .locked      (lk_a),
    .hsync       (a_hsync),
    .vsync       (a_vsync),
    .de          (a_de),
    .pixel_x     (a_px),
    .pixel_y     (a_py),
    .line_start  (a_ls),
    .frame_start (a_fs),
    .frame_cnt   (a_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE (8),
    .H_FP     (1),
    .H_SYNC   (2),
    .H_BP     (1),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .H_POL    (1'b1),
    .V_POL    (1'b0),
    .CW       (4)
  ) u_small (
    .clk_pix     (clk),
    .resetn      (resetn),
    .locked      (lk_b),
    .hsync       (b_hsync),
    .vsync       (b_vsync),
    .de          (b_de),
    .pixel_x     (b_px),
    .pixel_y     (b_py),
    .line_start  (b_ls),
    .frame_start (b_fs),
    .frame_cnt   (b_fc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    resetn = 1'b0;
    lk_a   = 1'b0;
    lk_b   = 1'b0;
    tick(3);

    check("a_rst_hsync", 32'(a_hsync), 1);
    check("a_rst_vsync", 32'(a_vsync), 1);
    check("a_rst_de",    32'(a_de),    0);
    check("a_rst_px",    32'(a_px),    0);
    check("a_rst_py",    32'(a_py),    0);
    check("a_rst_ls",    32'(a_ls),    0);
    check("a_rst_fs",    32'(a_fs),    0);
    check("a_rst_fc",    32'(a_fc),    0);
    check("b_rst_hsync", 32'(b_hsync), 0);
    check("b_rst_vsync", 32'(b_vsync), 1);

    resetn = 1'b1;
    lk_a   = 1'b1;
    tick(1);
    check("a_first_fs", 32'(a_fs), 1);
    check("a_first_ls", 32'(a_ls), 1);
    check("a_first_de", 32'(a_de), 1);
    check("a_first_px", 32'(a_px), 0);
    check("a_first_py", 32'(a_py), 0);
    check("a_first_fc", 32'(a_fc), 0);
    check("a_first_hs", 32'(a_hsync), 1);
    tick(1);
    check("a_second_px", 32'(a_px), 1);
    check("a_second_fs", 32'(a_fs), 0);
    check("a_second_ls", 32'(a_ls), 0);
    check("a_second_fc", 32'(a_fc), 1);

    de_n = 0; hs_n = 0; vs_n = 0; ls_n = 0; hs_first = -1; hs_last = -1;
    for (int i = 0; i < 800; i++) begin
      if (a_de) de_n++;
      if (a_ls) ls_n++;
      if (!a_vsync) vs_n++;
      if (!a_hsync) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(a_px);
        hs_last = int'(a_px);
      end
      tick(1);
    end
    check("a_line_de_cycles",  32'(de_n),     640);
    check("a_line_hs_cycles",  32'(hs_n),     96);
    check("a_line_hs_first_x", 32'(hs_first), 656);
    check("a_line_hs_last_x",  32'(hs_last),  751);
    check("a_line_ls_count",   32'(ls_n),     1);
    check("a_line_vs_cycles",  32'(vs_n),     0);
    check("a_line_end_px",     32'(a_px),     1);
    check("a_line_end_py",     32'(a_py),     1);

    tick(299);
    check("a_predrop_px", 32'(a_px), 300);
    check("a_predrop_py", 32'(a_py), 1);
    check("a_predrop_de", 32'(a_de), 1);
    lk_a = 1'b0;
    tick(1);
    check("a_drop_hsync", 32'(a_hsync), 1);
    check("a_drop_de",    32'(a_de),    0);
    check("a_drop_px",    32'(a_px),    0);
    check("a_drop_py",    32'(a_py),    0);
    check("a_drop_fs",    32'(a_fs),    0);
    check("a_drop_fc",    32'(a_fc),    1);
    tick(4);
    check("a_idle_px", 32'(a_px), 0);
    check("a_idle_ls", 32'(a_ls), 0);
    check("a_idle_fc", 32'(a_fc), 1);
    lk_a = 1'b1;
    tick(1);
    check("a_relock_px", 32'(a_px), 0);
    check("a_relock_py", 32'(a_py), 0);
    check("a_relock_fs", 32'(a_fs), 1);
    check("a_relock_ls", 32'(a_ls), 1);
    check("a_relock_de", 32'(a_de), 1);
    check("a_relock_fc", 32'(a_fc), 1);
    tick(1);
    check("a_relock2_fc", 32'(a_fc), 2);
    check("a_relock2_px", 32'(a_px), 1);

    tick(699);
    check("a_midsync_px",    32'(a_px),    700);
    check("a_midsync_hsync", 32'(a_hsync), 0);
    #2;
    resetn = 1'b0;
    #1;
    check("a_async_hsync", 32'(a_hsync), 1);
    check("a_async_vsync", 32'(a_vsync), 1);
    check("a_async_de",    32'(a_de),    0);
    check("a_async_px",    32'(a_px),    0);
    check("a_async_fc",    32'(a_fc),    0);

    tick(1);
    resetn = 1'b1;
    lk_a   = 1'b0;
    lk_b   = 1'b1;
    tick(1);
    check("b_first_fs",    32'(b_fs),    1);
    check("b_first_ls",    32'(b_ls),    1);
    check("b_first_de",    32'(b_de),    1);
    check("b_first_px",    32'(b_px),    0);
    check("b_first_py",    32'(b_py),    0);
    check("b_first_fc",    32'(b_fc),    0);
    check("b_first_hsync", 32'(b_hsync), 0);
    check("b_first_vsync", 32'(b_vsync), 1);

    de_n = 0; hs_n = 0; vs_n = 0; ls_n = 0; fs_n = 0; de_late = 0;
    hs_first = -1; vs_first_x = -1; vs_first_y = -1;
    for (int i = 0; i < 84; i++) begin
      if (b_de) de_n++;
      if (b_de && (b_py >= 4'd4)) de_late++;
      if (b_ls) ls_n++;
      if (b_fs) fs_n++;
      if (b_hsync) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(b_px);
      end
      if (!b_vsync) begin
        vs_n++;
        if (vs_first_y < 0) begin
          vs_first_x = int'(b_px);
          vs_first_y = int'(b_py);
        end
      end
      tick(1);
    end
    check("b_frame_de_cycles", 32'(de_n),       32);
    check("b_frame_de_late",   32'(de_late),    0);
    check("b_frame_hs_cycles", 32'(hs_n),       14);
    check("b_frame_hs_first",  32'(hs_first),   9);
    check("b_frame_vs_cycles", 32'(vs_n),       12);
    check("b_frame_vs_x",      32'(vs_first_x), 0);
    check("b_frame_vs_y",      32'(vs_first_y), 5);
    check("b_frame_ls_count",  32'(ls_n),       7);
    check("b_frame_fs_count",  32'(fs_n),       1);
    check("b_frame2_fs",       32'(b_fs),       1);
    check("b_frame2_fc",       32'(b_fc),       1);
    check("b_frame2_px",       32'(b_px),       0);
    check("b_frame2_py",       32'(b_py),       0);

    tick(84 * 254);
    check("b_f256_fs", 32'(b_fs), 1);
    check("b_f256_fc", 32'(b_fc), 255);
    tick(84);
    check("b_f257_fs", 32'(b_fs), 1);
    check("b_f257_fc", 32'(b_fc), 0);
    tick(1);
    check("b_f257_fc_next", 32'(b_fc), 1);

    tick(61);
    check("b_vs_py",    32'(b_py),    5);
    check("b_vs_px",    32'(b_px),    2);
    check("b_vs_vsync", 32'(b_vsync), 0);
    check("b_vs_hsync", 32'(b_hsync), 0);
    tick(7);
    check("b_hs_px",    32'(b_px),    9);
    check("b_hs_hsync", 32'(b_hsync), 1);
    check("b_hs_vsync", 32'(b_vsync), 0);
    #2;
    resetn = 1'b0;
    #1;
    check("b_async_hsync", 32'(b_hsync), 0);
    check("b_async_vsync", 32'(b_vsync), 1);
    check("b_async_de",    32'(b_de),    0);
    check("b_async_fc",    32'(b_fc),    0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
